// File: rtl/ercy_record_formatter.sv
// ERCY record formatter: drains compare-stage error FIFO records and emits each one
// as a 16-byte ASCII line. Optional sector padding is enabled by ERCY_SECTOR_PAD_EN.
module ercy_record_formatter (
    input  logic        fclk,
    input  logic        ureset,
    input  logic        outempty,
    input  logic        cmpdone,
    input  logic [31:0] VECTOROUT,
    input  logic [7:0]  SGNLNMNUM,
    input  logic        WSSGNLOUT,
    input  logic        GSSGNLOUT,
    input  logic        byte_ready,
    output logic        errrd,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    output logic [15:0] rec_count,
    output logic        ercy_done
);

`ifdef ERCY_SECTOR_PAD_EN
    typedef enum logic [2:0] {IDLE, RDREQ, LATCH, EMIT, PAD, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, RDREQ, LATCH, EMIT, DONE} state_t;
`endif

    state_t      r_state;
    logic        r_errrd;
    logic [7:0]  r_byte_out;
    logic        r_byte_valid;
    logic [15:0] r_rec_count;
    logic        r_ercy_done;
    logic [41:0] r_rec;
    logic [3:0]  r_byte_idx;
    logic [8:0]  r_sector;

    logic [41:0] w_fifo_rec;
    logic        w_xfer;

    assign w_fifo_rec = {VECTOROUT, SGNLNMNUM, WSSGNLOUT, GSSGNLOUT};
    assign w_xfer     = r_byte_valid & byte_ready;

    assign errrd      = r_errrd;
    assign byte_out   = r_byte_out;
    assign byte_valid = r_byte_valid;
    assign rec_count  = r_rec_count;
    assign ercy_done  = r_ercy_done;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Record layout: {vector[31:0], signal[7:0], expected, received}.
    function automatic logic [7:0] rec_byte(input logic [41:0] rec, input logic [3:0] idx);
        logic [31:0] vsh;
        logic [7:0]  ch;
        vsh = rec[41:10] << {idx[2:0], 2'b00};
        ch  = 8'h20;
        if (!idx[3]) begin
            ch = hex_char(vsh[31:28]);
        end else begin
            case (idx[2:0])
                3'd0:    ch = 8'h20;
                3'd1:    ch = hex_char(rec[9:6]);
                3'd2:    ch = hex_char(rec[5:2]);
                3'd3:    ch = 8'h20;
                3'd4:    ch = rec[1] ? 8'h31 : 8'h30;
                3'd5:    ch = rec[0] ? 8'h31 : 8'h30;
                3'd6:    ch = 8'h0D;
                3'd7:    ch = 8'h0A;
                default: ch = 8'h20;
            endcase
        end
        return ch;
    endfunction

    always_ff @(posedge fclk or posedge ureset) begin
        if (ureset) begin
            r_state      <= IDLE;
            r_errrd      <= 1'b0;
            r_byte_out   <= 8'h00;
            r_byte_valid <= 1'b0;
            r_rec_count  <= 16'h0000;
            r_ercy_done  <= 1'b0;
            r_rec        <= '0;
            r_byte_idx   <= 4'd0;
            r_sector     <= 9'd0;
        end else begin
            if (w_xfer) begin
                r_sector <= r_sector + 9'd1;
            end

            case (r_state)
                IDLE: begin
                    // Pending records always win over termination so the FIFOs drain first.
                    if (!outempty) begin
                        r_errrd <= 1'b1;
                        r_state <= RDREQ;
                    end else if (cmpdone) begin
`ifdef ERCY_SECTOR_PAD_EN
                        r_byte_out   <= 8'h20;
                        r_byte_valid <= (r_sector != 9'd0);
                        r_state      <= PAD;
`else
                        r_ercy_done  <= 1'b1;
                        r_state      <= DONE;
`endif
                    end
                end

                RDREQ: begin
                    r_errrd <= 1'b0;
                    r_state <= LATCH;
                end

                LATCH: begin
                    r_rec        <= w_fifo_rec;
                    r_byte_idx   <= 4'd0;
                    r_byte_out   <= rec_byte(w_fifo_rec, 4'd0);
                    r_byte_valid <= 1'b1;
                    r_state      <= EMIT;
                end

                EMIT: begin
                    if (w_xfer) begin
                        r_byte_idx <= r_byte_idx + 4'd1;
                        if (r_byte_idx == 4'd15) begin
                            r_byte_valid <= 1'b0;
                            if (r_rec_count != 16'hFFFF) begin
                                r_rec_count <= r_rec_count + 16'd1;
                            end
                            r_state <= IDLE;
                        end else begin
                            r_byte_out <= rec_byte(r_rec, r_byte_idx + 4'd1);
                        end
                    end
                end

`ifdef ERCY_SECTOR_PAD_EN
                PAD: begin
                    // Entered with byte_valid low when the sector is already aligned.
                    if (!r_byte_valid || (w_xfer && r_sector == 9'd511)) begin
                        r_byte_valid <= 1'b0;
                        r_ercy_done  <= 1'b1;
                        r_state      <= DONE;
                    end
                end
`endif

                DONE: begin
                    r_errrd      <= 1'b0;
                    r_byte_valid <= 1'b0;
                    r_ercy_done  <= 1'b1;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ercy_record_formatter.sv
// Directed testbench for ercy_record_formatter; acts as the error FIFO and the SD byte sink.
module tb_ercy_record_formatter;

    logic        fclk = 1'b0;
    logic        ureset;
    logic        outempty;
    logic        cmpdone;
    logic [31:0] VECTOROUT;
    logic [7:0]  SGNLNMNUM;
    logic        WSSGNLOUT;
    logic        GSSGNLOUT;
    logic        byte_ready;
    logic        errrd;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic [15:0] rec_count;
    logic        ercy_done;

    typedef struct {
        logic [31:0] v;
        logic [7:0]  s;
        logic        w;
        logic        g;
    } rec_t;

    rec_t       fifo_q[$];
    logic [7:0] got[$];
    int         errrd_cnt;
    int         checks = 0;
    int         errors = 0;

`ifdef ERCY_SECTOR_PAD_EN
    localparam int T3_TOTAL = 512;
    localparam int T4_TOTAL = 512;
`else
    localparam int T3_TOTAL = 48;
    localparam int T4_TOTAL = 32;
`endif

    ercy_record_formatter dut (
        .fclk       (fclk),
        .ureset     (ureset),
        .outempty   (outempty),
        .cmpdone    (cmpdone),
        .VECTOROUT  (VECTOROUT),
        .SGNLNMNUM  (SGNLNMNUM),
        .WSSGNLOUT  (WSSGNLOUT),
        .GSSGNLOUT  (GSSGNLOUT),
        .byte_ready (byte_ready),
        .errrd      (errrd),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .rec_count  (rec_count),
        .ercy_done  (ercy_done)
    );

    always #5 fclk = ~fclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs before the edge, then model FIFO pop and byte sink.
    task automatic tick();
        logic       pv, pr, pe;
        logic [7:0] pb;
        rec_t       r;
        pv = byte_valid;
        pr = byte_ready;
        pe = errrd;
        pb = byte_out;
        @(posedge fclk);
        #1;
        if (pe) begin
            errrd_cnt++;
            if (fifo_q.size() > 0) begin
                r = fifo_q.pop_front();
                VECTOROUT = r.v;
                SGNLNMNUM = r.s;
                WSSGNLOUT = r.w;
                GSSGNLOUT = r.g;
            end
            outempty = (fifo_q.size() == 0);
        end
        if (pv && pr) got.push_back(pb);
    endtask

    task automatic push(input logic [31:0] v, input logic [7:0] s, input logic w, input logic g);
        rec_t r;
        r.v = v;
        r.s = s;
        r.w = w;
        r.g = g;
        fifo_q.push_back(r);
        outempty = 1'b0;
    endtask

    task automatic do_reset();
        ureset     = 1'b1;
        cmpdone    = 1'b0;
        outempty   = 1'b1;
        byte_ready = 1'b1;
        fifo_q.delete();
        got.delete();
        errrd_cnt = 0;
        repeat (2) @(posedge fclk);
        #1;
        ureset = 1'b0;
    endtask

    // Compare 16 captured bytes at base against the 14-char text plus CR LF.
    task automatic chk_bytes(input string tag, input int base, input string txt);
        logic [7:0] o, e;
        for (int i = 0; i < 16; i++) begin
            if (base + i < got.size()) o = got[base + i];
            else                       o = 8'h00;
            if (i < 14)       e = txt[i];
            else if (i == 14) e = 8'h0D;
            else              e = 8'h0A;
            chk($sformatf("%s_b%0d", tag, i), 32'(o), 32'(e));
        end
    endtask

    initial begin
        int n;
        int stall;
        int nonpad;

        ureset     = 1'b1;
        outempty   = 1'b1;
        cmpdone    = 1'b0;
        byte_ready = 1'b1;
        VECTOROUT  = 32'h0;
        SGNLNMNUM  = 8'h0;
        WSSGNLOUT  = 1'b0;
        GSSGNLOUT  = 1'b0;
        errrd_cnt  = 0;

        // Reset state
        repeat (3) @(posedge fclk);
        #1;
        chk("rst_errrd",      32'(errrd),      32'd0);
        chk("rst_byte_valid", 32'(byte_valid), 32'd0);
        chk("rst_byte_out",   32'(byte_out),   32'h00);
        chk("rst_rec_count",  32'(rec_count),  32'd0);
        chk("rst_ercy_done",  32'(ercy_done),  32'd0);
        ureset = 1'b0;

        // Empty FIFO, compare not done: stay idle
        repeat (5) tick();
        chk("idle_byte_valid", 32'(byte_valid), 32'd0);
        chk("idle_errrd_cnt",  32'(errrd_cnt),  32'd0);
        chk("idle_ercy_done",  32'(ercy_done),  32'd0);

        // Basic record, byte_ready always high
        push(32'h0000012A, 8'h1F, 1'b1, 1'b0);
        n = 0;
        while (rec_count != 16'd1 && n < 200) begin tick(); n++; end
        chk("t1_timeout", 32'(n < 200), 32'd1);
        repeat (5) tick();
        chk("t1_nbytes", 32'(got.size()), 32'd16);
        chk_bytes("t1", 0, "0000012A 1F 10");
        chk("t1_errrd_cnt",  32'(errrd_cnt),  32'd1);
        chk("t1_rec_count",  32'(rec_count),  32'd1);
        chk("t1_byte_valid", 32'(byte_valid), 32'd0);

        // Same record with 3-cycle backpressure at index 5
        do_reset();
        push(32'h0000012A, 8'h1F, 1'b1, 1'b0);
        stall = 0;
        n = 0;
        while (rec_count != 16'd1 && n < 200) begin
            if (byte_valid && got.size() == 5 && stall < 3) begin
                byte_ready = 1'b0;
                chk("t2_hold_data",  32'(byte_out),   32'h31);
                chk("t2_hold_valid", 32'(byte_valid), 32'd1);
                stall++;
            end else begin
                byte_ready = 1'b1;
            end
            tick();
            n++;
        end
        byte_ready = 1'b1;
        chk("t2_timeout", 32'(n < 200), 32'd1);
        chk("t2_stalls",  32'(stall),   32'd3);
        chk("t2_nbytes",  32'(got.size()), 32'd16);
        chk_bytes("t2", 0, "0000012A 1F 10");

        // Three records, then termination
        do_reset();
        push(32'h0000012A, 8'h1F, 1'b1, 1'b0);
        push(32'hDEADBEEF, 8'hA5, 1'b0, 1'b1);
        push(32'h00000000, 8'h00, 1'b0, 1'b0);
        n = 0;
        while (rec_count != 16'd3 && n < 400) begin tick(); n++; end
        chk("t3_rec_timeout", 32'(n < 400), 32'd1);
        repeat (4) tick();
        chk("t3_idle_valid",     32'(byte_valid), 32'd0);
        chk("t3_idle_errrd",     32'(errrd),      32'd0);
        chk("t3_idle_errrd_cnt", 32'(errrd_cnt),  32'd3);
        chk("t3_idle_done",      32'(ercy_done),  32'd0);
        cmpdone = 1'b1;
        n = 0;
        while (!ercy_done && n < 1500) begin tick(); n++; end
        chk("t3_done_timeout", 32'(n < 1500), 32'd1);
        chk_bytes("t3_r0", 0,  "0000012A 1F 10");
        chk_bytes("t3_r1", 16, "DEADBEEF A5 01");
        chk_bytes("t3_r2", 32, "00000000 00 00");
        chk("t3_nbytes", 32'(got.size()), 32'(T3_TOTAL));
        nonpad = 0;
        for (int i = 48; i < got.size(); i++) if (got[i] != 8'h20) nonpad++;
        chk("t3_pad_content", 32'(nonpad), 32'd0);
        repeat (3) tick();
        chk("t3_sticky_done", 32'(ercy_done),   32'd1);
        chk("t3_done_valid",  32'(byte_valid),  32'd0);
        chk("t3_done_errrd",  32'(errrd),       32'd0);
        chk("t3_no_extra",    32'(got.size()),  32'(T3_TOTAL));
        chk("t3_rec_count",   32'(rec_count),   32'd3);

        // cmpdone raised while two records are still pending
        do_reset();
        push(32'hFFFFFFFF, 8'hFF, 1'b1, 1'b1);
        push(32'h9ABC0F3A, 8'h0B, 1'b1, 1'b1);
        cmpdone = 1'b1;
        n = 0;
        while (!ercy_done && n < 1500) begin tick(); n++; end
        chk("t4_timeout",   32'(n < 1500),   32'd1);
        chk("t4_rec_count", 32'(rec_count),  32'd2);
        chk("t4_errrd_cnt", 32'(errrd_cnt),  32'd2);
        chk_bytes("t4_r0", 0,  "FFFFFFFF FF 11");
        chk_bytes("t4_r1", 16, "9ABC0F3A 0B 11");
        chk("t4_nbytes", 32'(got.size()), 32'(T4_TOTAL));

        // 32 records fill exactly one sector, so no padding either way
        do_reset();
        for (int i = 0; i < 32; i++) begin
            logic [7:0] iv;
            iv = 8'(i);
            push({24'h0, iv}, iv, iv[0], iv[1]);
        end
        cmpdone = 1'b1;
        n = 0;
        while (!ercy_done && n < 2000) begin tick(); n++; end
        chk("t5_timeout",   32'(n < 2000),   32'd1);
        chk("t5_rec_count", 32'(rec_count),  32'd32);
        chk("t5_errrd_cnt", 32'(errrd_cnt),  32'd32);
        chk("t5_nbytes",    32'(got.size()), 32'd512);
        chk_bytes("t5_r31", 496, "0000001F 1F 11");

        // Reset in the middle of a record, then a fresh record
        do_reset();
        push(32'h0000012A, 8'h1F, 1'b1, 1'b0);
        n = 0;
        while (got.size() != 7 && n < 100) begin tick(); n++; end
        chk("t6_timeout",   32'(n < 100),   32'd1);
        chk("t6_mid_valid", 32'(byte_valid), 32'd1);
        chk("t6_mid_data",  32'(byte_out),   32'h41);
        ureset = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(byte_valid), 32'd0);
        chk("t6_rst_data",  32'(byte_out),   32'h00);
        chk("t6_rst_errrd", 32'(errrd),      32'd0);
        chk("t6_rst_count", 32'(rec_count),  32'd0);
        chk("t6_rst_done",  32'(ercy_done),  32'd0);
        tick();
        chk("t6_no_more_bytes", 32'(got.size()), 32'd7);
        do_reset();
        push(32'hDEADBEEF, 8'hA5, 1'b0, 1'b1);
        n = 0;
        while (rec_count != 16'd1 && n < 200) begin tick(); n++; end
        chk("t6_new_timeout", 32'(n < 200),   32'd1);
        chk("t6_new_nbytes",  32'(got.size()), 32'd16);
        chk_bytes("t6_new", 0, "DEADBEEF A5 01");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
